// File: rtl/axi4_master_engine.sv
// Single-outstanding AXI4 initiator turning a command/stream user interface into INCR bursts.
// Optional: define AXI4_MASTER_BOUNDARY_CHECK_EN to reject 4KB-crossing or over-wide commands.
module axi4_master_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic [1:0]            err_acc_q, err_acc_d;
    logic [1:0]            resp_q, resp_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  done_q, done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  in_w_s, in_r_s, w_hs_s, r_hs_s;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef AXI4_MASTER_BOUNDARY_CHECK_EN
    logic [23:0] span_end_s;
    logic        reject_s;
    assign span_end_s = {12'd0, cmd_addr[11:0]} + (({16'd0, cmd_len} + 24'd1) << cmd_size);
    assign reject_s   = (span_end_s > 24'd4096) || ((32'd1 << cmd_size) > 32'(DATA_WIDTH / 8));
`endif

    // Data channels are pure pass-through, gated by the owning state.
    assign in_w_s   = (state_q == S_W);
    assign in_r_s   = (state_q == S_R);
    assign WVALID   = in_w_s && wr_valid;
    assign WDATA    = wr_data;
    assign WLAST    = in_w_s && (beat_cnt_q == len_q);
    assign wr_ready = in_w_s && WREADY;
    assign rd_valid = in_r_s && RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = in_r_s && RLAST;
    assign RREADY   = in_r_s && rd_ready;
    assign w_hs_s   = in_w_s && wr_valid && WREADY;
    assign r_hs_s   = in_r_s && RVALID && rd_ready;

    assign cmd_ready = cmd_ready_q;
    assign done      = done_q;
    assign resp      = resp_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWVALID   = awvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARVALID   = arvalid_q;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        beat_cnt_d  = beat_cnt_q;
        err_acc_d   = err_acc_q;
        resp_d      = resp_q;
        awvalid_d   = awvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        cmd_ready_d = cmd_ready_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    size_d     = cmd_size;
                    beat_cnt_d = 8'd0;
                    err_acc_d  = 2'b00;
`ifdef AXI4_MASTER_BOUNDARY_CHECK_EN
                    if (reject_s) begin
                        done_d = 1'b1;
                        resp_d = 2'b10;
                    end else begin
                        cmd_ready_d = 1'b0;
                        state_d     = cmd_write ? S_AW : S_AR;
                        awvalid_d   = cmd_write;
                        arvalid_d   = !cmd_write;
                    end
`else
                    cmd_ready_d = 1'b0;
                    state_d     = cmd_write ? S_AW : S_AR;
                    awvalid_d   = cmd_write;
                    arvalid_d   = !cmd_write;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = S_W;
                end else begin
                    state_d = S_AW;
                end
            end
            S_W: begin
                if (w_hs_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_cnt_q == len_q) begin
                        state_d  = S_B;
                        bready_d = 1'b1;
                    end else begin
                        state_d = S_W;
                    end
                end else begin
                    state_d = S_W;
                end
            end
            S_B: begin
                if (BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    resp_d      = BRESP;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_B;
                end
            end
            S_AR: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (r_hs_s) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    err_acc_d  = resp_max(err_acc_q, RRESP);
                    // A slave that asserts RLAST early still terminates the burst.
                    if (RLAST || (beat_cnt_q == len_q)) begin
                        resp_d      = resp_max(err_acc_q, RRESP);
                        done_d      = 1'b1;
                        cmd_ready_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_R;
                    end
                end else begin
                    state_d = S_R;
                end
            end
            default: begin
                state_d     = S_IDLE;
                awvalid_d   = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops every handshake output at once.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            beat_cnt_q  <= 8'd0;
            err_acc_q   <= 2'b00;
            resp_q      <= 2'b00;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            beat_cnt_q  <= beat_cnt_d;
            err_acc_q   <= err_acc_d;
            resp_q      <= resp_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end
endmodule

// File: tb/tb_axi4_master_engine.sv
// Directed scoreboard bench for axi4_master_engine with a small AXI4 memory slave model.
module tb_axi4_master_engine;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_last, done;
    logic [1:0]  resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [1:0]  BRESP, RRESP;

    axi4_master_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .resp(resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int w_cnt = 0;
    int ar_run = 0;
    int last_ar_run = 0;
    int aw_delay = 0;
    int ar_delay = 0;
    bit rd_toggle = 1'b0;

    logic [26:0] exp_aw[$];
    logic [26:0] exp_ar[$];
    logic [32:0] exp_w[$];
    logic [32:0] exp_r[$];
    logic [1:0]  exp_done[$];
    logic [31:0] wq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic extra(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=unexpected_event expected=none", tag);
    endtask

    // Memory slave: 1024 words, anything at or above 0x1000 answers SLVERR.
    logic [31:0] mem [0:1023];
    int          aw_cnt, ar_cnt;
    logic        w_active, w_err, r_active, r_err;
    logic [9:0]  w_base, r_base;
    logic [7:0]  w_idx, r_idx, r_len;
    assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
    assign ARREADY = ARVALID && (ar_cnt >= ar_delay);
    assign WREADY  = w_active;
    assign RVALID  = r_active;
    assign RLAST   = r_active && (r_idx == r_len);
    assign RRESP   = r_err ? 2'b10 : 2'b00;
    assign RDATA   = r_err ? 32'hDEAD_BEEF : mem[r_base + 10'(r_idx)];

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h5500_0000 + 32'(i);
            aw_cnt <= 0; ar_cnt <= 0;
            w_active <= 1'b0; w_err <= 1'b0; w_base <= 10'd0; w_idx <= 8'd0;
            r_active <= 1'b0; r_err <= 1'b0; r_base <= 10'd0; r_idx <= 8'd0; r_len <= 8'd0;
            BVALID <= 1'b0; BRESP <= 2'b00;
        end else begin
            if (AWVALID && AWREADY) begin
                aw_cnt <= 0; w_active <= 1'b1; w_idx <= 8'd0;
                w_base <= AWADDR[11:2]; w_err <= (AWADDR >= 16'h1000);
            end else if (AWVALID) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (WVALID && WREADY) begin
                if (!w_err) mem[w_base + 10'(w_idx)] <= WDATA;
                w_idx <= w_idx + 8'd1;
                if (WLAST) begin
                    w_active <= 1'b0; BVALID <= 1'b1; BRESP <= w_err ? 2'b10 : 2'b00;
                end
            end
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                ar_cnt <= 0; r_active <= 1'b1; r_idx <= 8'd0; r_len <= ARLEN;
                r_base <= ARADDR[11:2]; r_err <= (ARADDR >= 16'h1000);
            end else if (ARVALID) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (RVALID && RREADY) begin
                r_idx <= r_idx + 8'd1;
                if (RLAST) r_active <= 1'b0;
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT produces handshakes.
    logic        ar_prev_v = 1'b0;
    logic [26:0] ar_prev;
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (AWVALID && AWREADY) begin
                if (exp_aw.size() == 0) extra("aw_extra");
                else chk("aw_cmd", {AWADDR, AWLEN, AWSIZE}, exp_aw.pop_front());
            end
            if (ARVALID && ar_prev_v) chk("ar_stable", {ARADDR, ARLEN, ARSIZE}, ar_prev);
            if (ARVALID) ar_run++;
            ar_prev_v = ARVALID && !ARREADY;
            ar_prev   = {ARADDR, ARLEN, ARSIZE};
            if (ARVALID && ARREADY) begin
                last_ar_run = ar_run;
                ar_run = 0;
                if (exp_ar.size() == 0) extra("ar_extra");
                else chk("ar_cmd", {ARADDR, ARLEN, ARSIZE}, exp_ar.pop_front());
            end
            if (WVALID && WREADY) begin
                w_cnt++;
                if (exp_w.size() == 0) extra("w_extra");
                else chk("w_beat", {WLAST, WDATA}, exp_w.pop_front());
            end
            if (rd_valid && rd_ready) begin
                if (exp_r.size() == 0) extra("r_extra");
                else chk("r_beat", {rd_last, rd_data}, exp_r.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("cmd_ready_at_done", cmd_ready, 1);
                if (exp_done.size() == 0) extra("done_extra");
                else chk("done_resp", resp, exp_done.pop_front());
            end
        end
    end

    task automatic step();
        logic hs;
        @(negedge ACLK);
        hs = wr_valid && wr_ready;
        @(posedge ACLK);
        #1;
        if (hs) void'(wq.pop_front());
        wr_valid = (wq.size() > 0);
        wr_data  = wr_valid ? wq[0] : 32'd0;
        if (rd_toggle) rd_ready = !rd_ready;
    endtask

    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_valid = 1'b1;
        wr_valid = (wq.size() > 0);
        wr_data  = wr_valid ? wq[0] : 32'd0;
        chk("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int prev = done_cnt;
        int n = 0;
        while (done_cnt == prev && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == prev) begin
            total++; bad++;
            $error("FAIL %s observed=timeout expected=done", tag);
        end
        chk({tag, "_queues_empty"}, exp_aw.size() + exp_ar.size() + exp_w.size() + exp_r.size(), 0);
    endtask

    initial begin
        int wc0, n;
        ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0;
        cmd_len = 8'd0; cmd_size = 3'd0; wr_data = 32'd0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, done, wr_ready, rd_valid}, 0);
        chk("rst_resp", resp, 0);
        chk("rst_addr_len_size", {AWADDR, AWLEN, AWSIZE, ARADDR, ARLEN, ARSIZE}, 0);
        ARESETn = 1'b1;
        step();

        // Write four beats to 0x0010 with an always-ready slave.
        exp_aw.push_back({16'h0010, 8'd3, 3'd2});
        for (int i = 0; i < 4; i++) begin
            wq.push_back(32'hA0 + 32'(i));
            exp_w.push_back({(i == 3) ? 1'b1 : 1'b0, 32'hA0 + 32'(i)});
        end
        exp_done.push_back(2'b00);
        send_cmd(1'b1, 16'h0010, 8'd3, 3'd2);
        chk("aw_latency", {AWVALID, ARVALID, cmd_ready}, 3'b100);
        wait_done("wr1", 50);

        // Read the same four words back.
        rd_ready = 1'b1;
        exp_ar.push_back({16'h0010, 8'd3, 3'd2});
        for (int i = 0; i < 4; i++) exp_r.push_back({(i == 3) ? 1'b1 : 1'b0, 32'hA0 + 32'(i)});
        exp_done.push_back(2'b00);
        send_cmd(1'b0, 16'h0010, 8'd3, 3'd2);
        chk("ar_latency", {ARVALID, AWVALID}, 2'b10);
        wait_done("rd1", 50);

        // Single-beat write outside the slave memory answers SLVERR.
        exp_aw.push_back({16'h1000, 8'd0, 3'd2});
        wq.push_back(32'h77);
        exp_w.push_back({1'b1, 32'h77});
        exp_done.push_back(2'b10);
        send_cmd(1'b1, 16'h1000, 8'd0, 3'd2);
        wait_done("wr_err", 50);
        step();
        chk("done_single_pulse", done, 0);

        // Eight-beat read with ARREADY delayed and rd_ready toggling; busy commands are ignored.
        ar_delay = 3; rd_toggle = 1'b1;
        exp_ar.push_back({16'h0010, 8'd7, 3'd2});
        for (int i = 0; i < 8; i++)
            exp_r.push_back({(i == 7) ? 1'b1 : 1'b0, (i < 4) ? 32'hA0 + 32'(i) : 32'h5500_0004 + 32'(i)});
        exp_done.push_back(2'b00);
        send_cmd(1'b0, 16'h0010, 8'd7, 3'd2);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0200;
        step();
        chk("busy_cmd_ready_low", cmd_ready, 0);
        step();
        chk("busy_cmd_ready_low2", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_done("rd_stall", 200);
        chk("arvalid_run", last_ar_run, 4);
        ar_delay = 0; rd_toggle = 1'b0; rd_ready = 1'b1;

        // Two-beat read from the error region accumulates SLVERR.
        exp_ar.push_back({16'h1000, 8'd1, 3'd2});
        exp_r.push_back({1'b0, 32'hDEAD_BEEF});
        exp_r.push_back({1'b1, 32'hDEAD_BEEF});
        exp_done.push_back(2'b10);
        send_cmd(1'b0, 16'h1000, 8'd1, 3'd2);
        wait_done("rd_err", 50);

`ifdef AXI4_MASTER_BOUNDARY_CHECK_EN
        // 0x0FF8 + 16 bytes crosses 4KB; size 3 exceeds a 4-byte bus.
        exp_done.push_back(2'b10);
        send_cmd(1'b1, 16'h0FF8, 8'd3, 3'd2);
        chk("reject_done_latency", {done, AWVALID, ARVALID}, 3'b100);
        step();
        exp_done.push_back(2'b10);
        send_cmd(1'b0, 16'h0100, 8'd0, 3'd3);
        chk("reject_size", {done, AWVALID, ARVALID}, 3'b100);
        step();
        chk("reject_done_count", exp_done.size(), 0);
`endif

        // Reset in the middle of a four-beat write.
        aw_delay = 1;
        exp_aw.push_back({16'h0040, 8'd3, 3'd2});
        for (int i = 0; i < 4; i++) wq.push_back(32'hB0 + 32'(i));
        exp_w.push_back({1'b0, 32'hB0});
        exp_w.push_back({1'b0, 32'hB1});
        send_cmd(1'b1, 16'h0040, 8'd3, 3'd2);
        wc0 = w_cnt; n = 0;
        while (w_cnt < wc0 + 2 && n < 50) begin
            step();
            n++;
        end
        chk("mid_write_beats", w_cnt - wc0, 2);
        wc0 = done_cnt;
        ARESETn = 1'b0;
        #1;
        chk("rst_async_wvalid", {WVALID, wr_ready, AWVALID, BREADY}, 0);
        wq.delete();
        wr_valid = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        step();
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_no_done", done_cnt - wc0, 0);
        aw_delay = 0;

        // A fresh write and readback after the reset.
        exp_aw.push_back({16'h0020, 8'd1, 3'd2});
        wq.push_back(32'hC0); wq.push_back(32'hC1);
        exp_w.push_back({1'b0, 32'hC0});
        exp_w.push_back({1'b1, 32'hC1});
        exp_done.push_back(2'b00);
        send_cmd(1'b1, 16'h0020, 8'd1, 3'd2);
        wait_done("wr_after_rst", 50);
        exp_ar.push_back({16'h0020, 8'd1, 3'd2});
        exp_r.push_back({1'b0, 32'hC0});
        exp_r.push_back({1'b1, 32'hC1});
        exp_done.push_back(2'b00);
        send_cmd(1'b0, 16'h0020, 8'd1, 3'd2);
        wait_done("rd_after_rst", 50);

        repeat (3) step();
        chk("final_done_queue", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_master_engine.md
Name: axi4_master_engine

Overview:
- Single-outstanding AXI4 initiator that converts a simple command/stream user interface into AXI4 INCR bursts.
- Drives all five AXI4 channels and connects directly to the team's memory-mapped AXI4 slave.
- Used as the bus driver for DMA-style traffic generators and for system-level loopback tests.
- Handles one transaction, write or read, at a time; the next command is not accepted until the current response completes.

Parameters:
- DATA_WIDTH, 32: AXI data width in bits.
- ADDR_WIDTH, 16: AXI address width in bits.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle and able to accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus 1 (AXI LEN encoding).
- cmd_size  in  3  bytes per beat = 2^size.
- wr_data / wr_valid / wr_ready  in / in / out  DATA_WIDTH / 1 / 1  user write-data stream.
- rd_data / rd_valid / rd_ready / rd_last  out / out / in / out  DATA_WIDTH / 1 / 1 / 1  user read-data stream.
- done  out  1  one-cycle pulse when a transaction completes.
- resp  out  2  final response, valid while done=1 and held until the next done.
- AWADDR, AWLEN, AWSIZE, AWVALID / AWREADY  out / in  AXI write address channel.
- WDATA, WVALID, WLAST / WREADY  out / in  AXI write data channel.
- BRESP, BVALID / BREADY  in / out  AXI write response channel.
- ARADDR, ARLEN, ARSIZE, ARVALID / ARREADY  out / in  AXI read address channel.
- RDATA, RRESP, RVALID, RLAST / RREADY  in / out  AXI read data channel.

Behaviour:
- Reset values: AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, done, wr_ready and rd_valid are all 0. resp = 2'b00. Address, LEN and SIZE outputs are 0. cmd_ready = 1. The state machine is in IDLE.
- States: IDLE, AW, W, B, AR, R. An unknown state returns to IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch addr/len/size/write and clear beat_cnt and err_acc.
  - Next state is AW if cmd_write, otherwise AR.
  - The VALID of the chosen address channel is registered high on the first cycle of AW or AR.
- AW:
  - AWVALID = 1 with AWADDR/AWLEN/AWSIZE held stable until AWREADY is sampled high.
  - AWVALID drops the cycle after the handshake; then go to W.
- W (combinational pass-through):
  - WVALID = wr_valid; WDATA = wr_data; wr_ready = WREADY.
  - WLAST = (beat_cnt == len).
  - Each WVALID && WREADY handshake increments beat_cnt (8-bit).
  - The handshake with WLAST = 1 moves the engine to B.
  - No WVALID or wr_ready outside state W.
- B:
  - BREADY = 1.
  - On BVALID: resp <= BRESP, done pulses, return to IDLE.
- AR: same as AW, using the AR channel; then go to R.
- R (combinational pass-through):
  - rd_valid = RVALID; rd_data = RDATA; rd_last = RLAST; RREADY = rd_ready.
  - Each handshake increments beat_cnt and sets err_acc <= max(err_acc, RRESP).
  - The burst ends on the handshake where RLAST = 1 OR beat_cnt == len, whichever comes first.
  - At the end of the burst: resp <= max(err_acc, RRESP), done pulses, return to IDLE.
- Latency:
  - Command accept to AWVALID/ARVALID is 1 cycle.
  - Last B or R handshake to done is 1 cycle.
  - cmd_ready returns high in the same cycle that done is high.
- Back-pressure: any number of stall cycles on either side is tolerated; a stall never drops or duplicates a beat.
- A cmd_valid that arrives while the engine is busy is ignored, and cmd_ready stays low.
- Reset during a transaction: all VALID/READY outputs drop immediately (asynchronous reset), the state returns to IDLE and no done is issued.

Optional Feature:
- Macro: AXI4_MASTER_BOUNDARY_CHECK_EN.
- When defined:
  - In IDLE, a command is rejected if addr[11:0] + ((len+1) << size) > 4096, or if 2^size > DATA_WIDTH/8.
  - A rejected command is still accepted (cmd_ready handshake), but no AXI channel activity occurs.
  - The next cycle, done = 1 and resp = 2'b10.
- When undefined: every command is issued unchanged on the bus.

Test Plan:
- Write addr 0x0010, len 3, size 2, data 0xA0..0xA3, slave always ready -> AWADDR 0x0010 / AWLEN 3; 4 W beats with WLAST only on 0xA3; done with resp 00.
- Read back the same command -> rd_data 0xA0, 0xA1, 0xA2, 0xA3; rd_last on beat 4; done with resp 00.
- Write to 0x1000 (beyond 1024-word memory), len 0 -> slave returns BRESP 10 -> resp 10, done once.
- Read len 7 with rd_ready toggling every cycle and the slave delaying ARREADY by 3 cycles -> ARVALID stays stable for 4 cycles; 8 beats in order; no lost beats.
- With AXI4_MASTER_BOUNDARY_CHECK_EN: addr 0x0FF8, len 3, size 2 -> no AWVALID; done with resp 10 one cycle after accept.
- Assert ARESETn low during a W beat 2 of 4 -> WVALID = 0 immediately; after release, cmd_ready = 1 and a fresh write completes with resp 00.
